ps2_host_tx: RTL and testbench

//  Host-to-device PS/2 transmitter: sends one command byte (e.g. 0xED set-LEDs, 0xFF reset) to the keyboard

---
 rtl/ps2_host_tx_if.sv | 23 ++
 rtl/ps2_host_tx.sv | 158 +++++++++++++++
 tb/tb_ps2_host_tx.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/ps2_host_tx_if.sv
// rtl/ps2_host_tx_if.sv - command handshake and PS/2 pin bundle for ps2_host_tx
interface ps2_host_tx_if;
    logic       key_clk;
    logic       key_data;
    logic       key_clk_oe;
    logic       key_data_oe;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       tx_busy;
    logic       tx_done;
    logic       tx_err;

    modport master (
        output tx_data, tx_valid, key_clk, key_data,
        input  key_clk_oe, key_data_oe, tx_ready, tx_busy, tx_done, tx_err
    );

    modport slave (
        input  tx_data, tx_valid, key_clk, key_data,
        output key_clk_oe, key_data_oe, tx_ready, tx_busy, tx_done, tx_err
    );
endinterface

// File: rtl/ps2_host_tx.sv
// rtl/ps2_host_tx.sv - PS/2 host-to-device command transmitter
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES     = 10_000,
    parameter int REQ_TIMEOUT_CYCLES = 1_500_000,
    parameter int BIT_TIMEOUT_CYCLES = 200_000
) (
    input  logic         clk_in,
    input  logic         rst,
    ps2_host_tx_if.slave bus
);
    localparam int MAX_AB = (INHIBIT_CYCLES > REQ_TIMEOUT_CYCLES) ? INHIBIT_CYCLES : REQ_TIMEOUT_CYCLES;
    localparam int MAX_P  = (MAX_AB > BIT_TIMEOUT_CYCLES) ? MAX_AB : BIT_TIMEOUT_CYCLES;
    localparam int CW     = $clog2(MAX_P + 1);

    localparam logic [CW-1:0] CNT_SAT  = {CW{1'b1}};
    localparam logic [CW-1:0] INH_LAST = CW'(INHIBIT_CYCLES - 1);
    localparam logic [CW-1:0] REQ_LAST = CW'(REQ_TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] BIT_LAST = CW'(BIT_TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        REQ,
        SHIFT,
        ACK,
        WAITIDLE,
        ERR
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [3:0]    nedge;
    logic [9:0]    frame;
    logic          clk_oe_q;
    logic          data_oe_q;
    logic          done_q;
    logic          err_q;

    logic          clk_s1;
    logic          clk_s2;
    logic          clk_prev;
    logic          dat_s1;
    logic          dat_s2;
    logic          clk_fall;

    // Two-flop synchronizers on both pins plus one history flop for edge detection
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            clk_s1   <= 1'b1;
            clk_s2   <= 1'b1;
            clk_prev <= 1'b1;
            dat_s1   <= 1'b1;
            dat_s2   <= 1'b1;
        end else begin
            clk_s1   <= bus.key_clk;
            clk_s2   <= clk_s1;
            clk_prev <= clk_s2;
            dat_s1   <= bus.key_data;
            dat_s2   <= dat_s1;
        end
    end

    assign clk_fall = clk_prev & ~clk_s2;

    // Frame sequencer: one shared saturating counter serves inhibit time and all timeouts
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            nedge     <= '0;
            frame     <= '0;
            clk_oe_q  <= 1'b0;
            data_oe_q <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            cnt    <= (cnt == CNT_SAT) ? cnt : cnt + 1'b1;
            case (state)
                IDLE: begin
                    clk_oe_q  <= 1'b0;
                    data_oe_q <= 1'b0;
                    if (bus.tx_valid) begin
                        frame    <= {1'b1, ~^bus.tx_data, bus.tx_data};
                        cnt      <= '0;
                        clk_oe_q <= 1'b1;
                        state    <= INHIBIT;
                    end
                end
                INHIBIT: begin
                    if (cnt == INH_LAST) begin
                        clk_oe_q  <= 1'b0;
                        data_oe_q <= 1'b1;
                        cnt       <= '0;
                        nedge     <= '0;
                        state     <= REQ;
                    end
                end
                // REQ waits for edge 1; SHIFT handles edges 2..10, both put the next frame bit out
                REQ, SHIFT: begin
                    if (clk_fall) begin
                        data_oe_q <= ~frame[0];
                        frame     <= {1'b0, frame[9:1]};
                        nedge     <= nedge + 4'd1;
                        cnt       <= '0;
                        state     <= (nedge == 4'd9) ? ACK : SHIFT;
                    end else if (cnt == ((state == REQ) ? REQ_LAST : BIT_LAST)) begin
                        clk_oe_q  <= 1'b0;
                        data_oe_q <= 1'b0;
                        err_q     <= 1'b1;
                        state     <= ERR;
                    end
                end
                ACK: begin
                    if (clk_fall) begin
                        cnt <= '0;
                        if (!dat_s2) begin
                            state <= WAITIDLE;
                        end else begin
                            err_q <= 1'b1;
                            state <= ERR;
                        end
                    end else if (cnt == BIT_LAST) begin
                        err_q <= 1'b1;
                        state <= ERR;
                    end
                end
                // done is raised while still busy so the next accept lands one cycle after it
                WAITIDLE: begin
                    if (done_q) begin
                        state <= IDLE;
                    end else if (clk_s2 && dat_s2) begin
                        done_q <= 1'b1;
                    end else if (cnt == BIT_LAST) begin
                        err_q <= 1'b1;
                        state <= ERR;
                    end
                end
                ERR: begin
                    clk_oe_q  <= 1'b0;
                    data_oe_q <= 1'b0;
                    state     <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.key_clk_oe  = clk_oe_q;
    assign bus.key_data_oe = data_oe_q;
    assign bus.tx_done     = done_q;
    assign bus.tx_err      = err_q;
    assign bus.tx_ready    = (state == IDLE);
    assign bus.tx_busy     = (state != IDLE);
endmodule

// File: tb/tb_ps2_host_tx.sv
// tb/tb_ps2_host_tx.sv - directed self-checking bench for ps2_host_tx
`timescale 1ns/1ps
module tb_ps2_host_tx;
    localparam int INH  = 20;
    localparam int REQT = 400;
    localparam int BITT = 200;
    localparam int H    = 20;

    logic clk_in = 1'b0;
    logic rst    = 1'b1;
    logic dev_clk_low  = 1'b0;
    logic dev_data_low = 1'b0;
    bit   busy_gap;
    int   n_cmp  = 0;
    int   n_fail = 0;
    int   done_cnt = 0;
    int   err_cnt  = 0;

    ps2_host_tx_if bus ();

    assign bus.key_clk  = ~(bus.key_clk_oe | dev_clk_low);
    assign bus.key_data = ~(bus.key_data_oe | dev_data_low);

    ps2_host_tx #(
        .INHIBIT_CYCLES    (INH),
        .REQ_TIMEOUT_CYCLES(REQT),
        .BIT_TIMEOUT_CYCLES(BITT)
    ) dut (
        .clk_in(clk_in),
        .rst   (rst),
        .bus   (bus)
    );

    always #5 clk_in = ~clk_in;

    always @(negedge clk_in) begin
        if (bus.tx_done === 1'b1) done_cnt <= done_cnt + 1;
        if (bus.tx_err === 1'b1) err_cnt <= err_cnt + 1;
    end

    initial begin
        #800_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic accept(input logic [7:0] b, input bit keep_valid, input logic [7:0] after_data);
        @(negedge clk_in);
        bus.tx_data  = b;
        bus.tx_valid = 1'b1;
        @(negedge clk_in);
        bus.tx_valid = keep_valid;
        bus.tx_data  = after_data;
    endtask

    task automatic device(input int n, input bit ack_low, output logic [9:0] bits, output bit ok);
        int t;
        ok   = 1'b1;
        bits = '0;
        t    = 0;
        while (!(bus.key_clk === 1'b1 && bus.key_data === 1'b0) && t < 2000) begin
            @(negedge clk_in);
            t++;
        end
        if (t >= 2000) begin
            ok = 1'b0;
            return;
        end
        for (int i = 1; i <= n; i++) begin
            repeat (H) @(negedge clk_in);
            dev_clk_low = 1'b1;
            repeat (H) @(negedge clk_in);
            if (i <= 10) bits[i-1] = bus.key_data;
            if (bus.tx_busy !== 1'b1) busy_gap = 1'b1;
            dev_clk_low = 1'b0;
            if (i == 10) dev_data_low = ack_low;
        end
        dev_data_low = 1'b0;
    endtask

    task automatic test_reset();
        bus.tx_valid = 1'b0;
        bus.tx_data  = 8'h00;
        rst = 1'b1;
        repeat (3) @(negedge clk_in);
        n_cmp++; if (bus.key_clk_oe !== 1'b0) begin n_fail++; $display("FAIL reset_clk_oe: got %b want 0", bus.key_clk_oe); end
        n_cmp++; if (bus.key_data_oe !== 1'b0) begin n_fail++; $display("FAIL reset_data_oe: got %b want 0", bus.key_data_oe); end
        n_cmp++; if (bus.tx_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", bus.tx_ready); end
        n_cmp++; if (bus.tx_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", bus.tx_busy); end
        n_cmp++; if ({bus.tx_done, bus.tx_err} !== 2'b00) begin n_fail++; $display("FAIL reset_pulses: got %b want 00", {bus.tx_done, bus.tx_err}); end
        rst = 1'b0;
        repeat (3) @(negedge clk_in);
    endtask

    task automatic test_send_ed();
        logic [9:0] bits;
        bit ok;
        int d0, e0;
        d0 = done_cnt; e0 = err_cnt; busy_gap = 1'b0;
        accept(8'hED, 1'b0, 8'h00);
        n_cmp++; if (bus.key_clk_oe !== 1'b1) begin n_fail++; $display("FAIL ed_latency: clk_oe got %b want 1", bus.key_clk_oe); end
        device(11, 1'b1, bits, ok);
        n_cmp++; if (ok !== 1'b1) begin n_fail++; $display("FAIL ed_request: request not seen got %b want 1", ok); end
        n_cmp++; if (bits !== 10'b11_1110_1101) begin n_fail++; $display("FAIL ed_bits: got %b want %b", bits, 10'b11_1110_1101); end
        n_cmp++; if (busy_gap !== 1'b0) begin n_fail++; $display("FAIL ed_busy: busy dropped got %b want 0", busy_gap); end
        repeat (30) @(negedge clk_in);
        n_cmp++; if (done_cnt - d0 !== 1) begin n_fail++; $display("FAIL ed_done: got %0d pulses want 1", done_cnt - d0); end
        n_cmp++; if (err_cnt - e0 !== 0) begin n_fail++; $display("FAIL ed_err: got %0d pulses want 0", err_cnt - e0); end
    endtask

    task automatic test_send_02();
        logic [9:0] bits;
        bit ok;
        int d0, c;
        d0 = done_cnt;
        accept(8'h02, 1'b0, 8'hFF);
        c = 0;
        while (bus.key_clk_oe === 1'b1 && c < 1000) begin
            c++;
            @(negedge clk_in);
        end
        n_cmp++; if (c !== INH) begin n_fail++; $display("FAIL x02_inhibit: got %0d cycles want %0d", c, INH); end
        device(11, 1'b1, bits, ok);
        n_cmp++; if (bits !== 10'b10_0000_0010 || !ok) begin n_fail++; $display("FAIL x02_bits: got %b want %b", bits, 10'b10_0000_0010); end
        repeat (30) @(negedge clk_in);
        n_cmp++; if (done_cnt - d0 !== 1) begin n_fail++; $display("FAIL x02_done: got %0d pulses want 1", done_cnt - d0); end
    endtask

    task automatic test_req_timeout();
        int t, c, d0;
        d0 = done_cnt;
        accept(8'h55, 1'b0, 8'h00);
        t = 0;
        while (bus.key_data_oe !== 1'b1 && t < 1000) begin
            @(negedge clk_in);
            t++;
        end
        c = 0;
        while (bus.tx_err !== 1'b1 && c < 2000) begin
            @(negedge clk_in);
            c++;
        end
        n_cmp++; if (c !== REQT) begin n_fail++; $display("FAIL req_timeout: got %0d cycles want %0d", c, REQT); end
        n_cmp++; if ({bus.key_clk_oe, bus.key_data_oe} !== 2'b00) begin n_fail++; $display("FAIL req_err_oe: got %b want 00", {bus.key_clk_oe, bus.key_data_oe}); end
        @(negedge clk_in);
        n_cmp++; if (bus.tx_ready !== 1'b1 || bus.tx_err !== 1'b0) begin n_fail++; $display("FAIL req_after: ready/err got %b%b want 10", bus.tx_ready, bus.tx_err); end
        n_cmp++; if (done_cnt - d0 !== 0) begin n_fail++; $display("FAIL req_done: got %0d pulses want 0", done_cnt - d0); end
    endtask

    task automatic test_no_ack();
        logic [9:0] bits;
        bit ok;
        int d0, e0;
        d0 = done_cnt; e0 = err_cnt;
        accept(8'hF4, 1'b0, 8'h00);
        device(11, 1'b0, bits, ok);
        n_cmp++; if (bits !== 10'b10_1111_0100 || !ok) begin n_fail++; $display("FAIL noack_bits: got %b want %b", bits, 10'b10_1111_0100); end
        repeat (30) @(negedge clk_in);
        n_cmp++; if (err_cnt - e0 !== 1) begin n_fail++; $display("FAIL noack_err: got %0d pulses want 1", err_cnt - e0); end
        n_cmp++; if (done_cnt - d0 !== 0) begin n_fail++; $display("FAIL noack_done: got %0d pulses want 0", done_cnt - d0); end
    endtask

    task automatic test_reset_midframe();
        logic [9:0] bits;
        bit ok;
        int d0, e0;
        d0 = done_cnt; e0 = err_cnt;
        accept(8'h02, 1'b0, 8'h00);
        device(4, 1'b1, bits, ok);
        n_cmp++; if (bus.key_data_oe !== 1'b1 || bus.tx_busy !== 1'b1) begin n_fail++; $display("FAIL rst_pre: data_oe/busy got %b%b want 11", bus.key_data_oe, bus.tx_busy); end
        #2 rst = 1'b1;
        #1;
        n_cmp++; if ({bus.key_clk_oe, bus.key_data_oe} !== 2'b00) begin n_fail++; $display("FAIL rst_async: got %b want 00", {bus.key_clk_oe, bus.key_data_oe}); end
        repeat (3) @(negedge clk_in);
        rst = 1'b0;
        repeat (10) @(negedge clk_in);
        n_cmp++; if (bus.tx_ready !== 1'b1 || bus.tx_busy !== 1'b0) begin n_fail++; $display("FAIL rst_idle: ready/busy got %b%b want 10", bus.tx_ready, bus.tx_busy); end
        n_cmp++; if (done_cnt != d0 || err_cnt != e0) begin n_fail++; $display("FAIL rst_pulses: done/err got %0d/%0d want 0/0", done_cnt - d0, err_cnt - e0); end
    endtask

    task automatic test_back_to_back();
        logic [9:0] bits;
        bit ok;
        int d0, t;
        d0 = done_cnt;
        accept(8'hED, 1'b1, 8'hAA);
        device(11, 1'b1, bits, ok);
        n_cmp++; if (bits !== 10'b11_1110_1101 || !ok) begin n_fail++; $display("FAIL b2b_first_bits: got %b want %b", bits, 10'b11_1110_1101); end
        t = 0;
        while (bus.tx_done !== 1'b1 && t < 100) begin
            @(negedge clk_in);
            t++;
        end
        n_cmp++; if (bus.tx_done !== 1'b1) begin n_fail++; $display("FAIL b2b_done_wait: tx_done got %b want 1", bus.tx_done); end
        @(negedge clk_in);
        n_cmp++; if (bus.tx_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready: got %b want 1", bus.tx_ready); end
        @(negedge clk_in);
        n_cmp++; if (bus.key_clk_oe !== 1'b1 || bus.tx_busy !== 1'b1) begin n_fail++; $display("FAIL b2b_accept: clk_oe/busy got %b%b want 11", bus.key_clk_oe, bus.tx_busy); end
        bus.tx_valid = 1'b0;
        device(11, 1'b1, bits, ok);
        n_cmp++; if (bits !== 10'b11_1010_1010 || !ok) begin n_fail++; $display("FAIL b2b_second_bits: got %b want %b", bits, 10'b11_1010_1010); end
        repeat (30) @(negedge clk_in);
        n_cmp++; if (done_cnt - d0 !== 2) begin n_fail++; $display("FAIL b2b_done: got %0d pulses want 2", done_cnt - d0); end
    endtask

    initial begin
        test_reset();
        test_send_ed();
        test_send_02();
        test_req_timeout();
        test_no_ack();
        test_reset_midframe();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
